// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: EX-stage mul/div request, pipeline hold and hi/lo write-back bundle.
interface ex_muldiv_if;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] opa_i;
    logic [31:0] opb_i;
    logic        flush_i;
    logic        stall_o;
    logic        busy_o;
    logic [63:0] wdata_o;
    logic        mt_hi_o;
    logic        mt_lo_o;
    modport master (output start_i, op_i, opa_i, opb_i, flush_i,
                    input  stall_o, busy_o, wdata_o, mt_hi_o, mt_lo_o);
    modport slave  (input  start_i, op_i, opa_i, opb_i, flush_i,
                    output stall_o, busy_o, wdata_o, mt_hi_o, mt_lo_o);
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle MULT/MULTU/DIV/DIVU unit producing {hi,lo} with one-cycle write enables.
module ex_muldiv #(
    parameter int DIV_ITER = 32
) (
    input logic        clk_i,
    input logic        rst_i,
    ex_muldiv_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t      state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d, rem_q, rem_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        sgn_q, sgn_d, negq_q, negq_d, negr_q, negr_d;
    logic [63:0] res_q, res_d;
    logic        sgn, accept, div0;
    logic [31:0] abs_a, abs_b, rem_n, quo_n;
    logic [32:0] sh, diff;
    logic [63:0] prod;
    assign sgn    = ~bus.op_i[0];
    assign accept = bus.start_i & ~bus.flush_i;
    assign div0   = bus.opb_i == 32'd0;
    assign abs_a  = (sgn & bus.opa_i[31]) ? -bus.opa_i : bus.opa_i;
    assign abs_b  = (sgn & bus.opb_i[31]) ? -bus.opb_i : bus.opb_i;
    // a_q doubles as the dividend shift register that collects quotient bits
    assign sh     = {rem_q, a_q[31]};
    assign diff   = sh - {1'b0, b_q};
    assign rem_n  = diff[32] ? sh[31:0] : diff[31:0];
    assign quo_n  = {a_q[30:0], ~diff[32]};
    assign prod   = {{32{sgn_q & a_q[31]}}, a_q} * {{32{sgn_q & b_q[31]}}, b_q};
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        res_d   = res_q;
        case (state_q)
            IDLE: if (accept) begin
                a_d     = bus.op_i[1] ? abs_a : bus.opa_i;
                b_d     = bus.op_i[1] ? abs_b : bus.opb_i;
                sgn_d   = sgn;
                negq_d  = sgn & (bus.opa_i[31] ^ bus.opb_i[31]);
                negr_d  = sgn & bus.opa_i[31];
                rem_d   = 32'd0;
                cnt_d   = 5'd0;
                state_d = !bus.op_i[1] ? MUL : (div0 ? DONE : DIV);
                res_d   = (bus.op_i[1] && div0) ? {bus.opa_i, 32'hFFFF_FFFF} : res_q;
            end
            MUL: begin
                res_d   = prod;
                state_d = DONE;
            end
            DIV: begin
                a_d   = quo_n;
                rem_d = rem_n;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(DIV_ITER - 1)) begin
                    state_d = DONE;
                    res_d   = {negr_q ? -rem_n : rem_n, negq_q ? -quo_n : quo_n};
                end
            end
            default: state_d = IDLE;
        endcase
        if (bus.flush_i) begin
            state_d = IDLE;
            res_d   = res_q;
        end
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            res_q   <= res_d;
        end
    end
    assign bus.busy_o  = (state_q == MUL) || (state_q == DIV);
    assign bus.stall_o = ~rst_i & ~bus.flush_i & (((state_q == IDLE) & bus.start_i) | bus.busy_o);
    assign bus.mt_hi_o = (state_q == DONE) & ~bus.flush_i;
    assign bus.mt_lo_o = bus.mt_hi_o;
    assign bus.wdata_o = res_q;
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed mul/div vectors; expected {hi,lo} queued at issue, checked by a write-back monitor.
module tb_ex_muldiv;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    ex_muldiv_if bus ();
    ex_muldiv dut (.clk_i(clk), .rst_i(rst), .bus(bus));
    logic [63:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask
    always @(negedge clk) begin
        if (bus.mt_hi_o || bus.mt_lo_o) begin
            chk("mt_hi_eq_mt_lo", 64'(bus.mt_lo_o), 64'(bus.mt_hi_o));
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_writeback: got wdata %h expected no pulse", bus.wdata_o);
            end else begin
                chk("wdata", bus.wdata_o, exp_q.pop_front());
            end
        end
    end
    task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input int lat, input bit pre, input bit keep,
                       input string name);
        int n;
        int low;
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.opa_i   = a;
        bus.opb_i   = b;
        exp_q.push_back(exp);
        if (pre) @(negedge clk);
        #1 chk({name, "_stall_T"}, 64'(bus.stall_o), 64'd1);
        n   = 0;
        low = 0;
        do begin
            @(negedge clk);
            n++;
            if (!bus.mt_hi_o && !bus.stall_o) low++;
        end while (!bus.mt_hi_o && n < 100);
        chk({name, "_latency"}, 64'(n), 64'(lat));
        chk({name, "_stall_gaps"}, 64'(low), 64'd0);
        chk({name, "_stall_done"}, 64'(bus.stall_o), 64'd0);
        if (!keep) bus.start_i = 1'b0;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
    initial begin
        bus.start_i = 1'b0;
        bus.op_i    = 2'd0;
        bus.opa_i   = 32'd0;
        bus.opb_i   = 32'd0;
        bus.flush_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_stall", 64'(bus.stall_o), 64'd0);
        chk("rst_busy", 64'(bus.busy_o), 64'd0);
        chk("rst_mt", 64'(bus.mt_hi_o), 64'd0);
        chk("rst_wdata", bus.wdata_o, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        run(2'b00, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 2, 0, 0, "mult_neg");
        @(negedge clk);
        chk("mult_idle_busy", 64'(bus.busy_o), 64'd0);
        chk("mult_idle_mt", 64'(bus.mt_hi_o), 64'd0);
        chk("wdata_hold", bus.wdata_o, 64'hFFFF_FFFF_FFFF_FFF1);
        run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 2, 0, 0, "multu_max");
        @(negedge clk);
        run(2'b11, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 33, 0, 0, "divu_100_7");
        @(negedge clk);
        run(2'b10, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33, 0, 0, "div_m7_2");
        @(negedge clk);
        run(2'b10, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 33, 0, 0, "div_7_m2");
        @(negedge clk);
        run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 33, 0, 0, "div_ovf");
        @(negedge clk);
        run(2'b10, 32'd5, 32'd0, 64'h0000_0005_FFFF_FFFF, 1, 0, 0, "div_by_zero");
        @(negedge clk);
        run(2'b11, 32'd3, 32'd0, 64'h0000_0003_FFFF_FFFF, 1, 0, 0, "divu_by_zero");
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = 2'b00;
        bus.flush_i = 1'b1;
        #1 chk("flush_start_stall", 64'(bus.stall_o), 64'd0);
        @(negedge clk);
        chk("flush_start_busy", 64'(bus.busy_o), 64'd0);
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = 2'b10;
        bus.opa_i   = 32'd1000;
        bus.opb_i   = 32'd3;
        #1 chk("flush_div_stall_T", 64'(bus.stall_o), 64'd1);
        repeat (10) @(negedge clk);
        bus.flush_i = 1'b1;
        #1 chk("flush_div_stall", 64'(bus.stall_o), 64'd0);
        chk("flush_div_busy_before", 64'(bus.busy_o), 64'd1);
        @(negedge clk);
        chk("flush_div_busy_after", 64'(bus.busy_o), 64'd0);
        bus.flush_i = 1'b0;
        bus.start_i = 1'b0;
        @(negedge clk);
        run(2'b01, 32'd2, 32'd3, 64'd6, 2, 0, 0, "multu_after_flush");
        repeat (40) @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = 2'b11;
        bus.opa_i   = 32'd1000;
        bus.opb_i   = 32'd7;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("arst_stall", 64'(bus.stall_o), 64'd0);
        chk("arst_busy", 64'(bus.busy_o), 64'd0);
        chk("arst_mt", 64'(bus.mt_hi_o), 64'd0);
        chk("arst_wdata", bus.wdata_o, 64'd0);
        bus.start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run(2'b00, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 2, 0, 1, "b2b_mult");
        run(2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 64'h0000_000F_0FFF_FFFF, 33, 1, 0, "b2b_divu");
        repeat (5) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
Multi-cycle multiply/divide unit inside the EX stage. It executes MULT, MULTU, DIV and DIVU and produces a 64-bit {hi,lo} result with hi/lo write enables. These outputs feed the MEM stage's hi/lo register write port (wdata/mt_hi/mt_lo). While an operation is in flight it holds the pipeline through stall_o. Pipeline flushes abort it.

Parameters:
DIV_ITER, 32, number of restoring-division iterations (fixed to operand width; not intended to be changed)

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  asynchronous reset, active-high
start_i  input  1  EX holds a mul/div instruction; level, held while stall_o is high
op_i  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start_i in IDLE
opa_i  input  32  rs operand (multiplicand / dividend)
opb_i  input  32  rt operand (multiplier / divisor)
flush_i  input  1  pipeline flush (exception/eret); aborts current operation
stall_o  output  1  request to hold IF/ID/EX; combinational
busy_o  output  1  registered; high in MUL or DIV state
wdata_o  output  64  {hi,lo} result; valid only while mt_hi_o/mt_lo_o are high
mt_hi_o  output  1  write hi in MEM; one-cycle pulse
mt_lo_o  output  1  write lo in MEM; one-cycle pulse

Behaviour:
- Reset (async, any state): state=IDLE; wdata_o=0, mt_hi_o=mt_lo_o=0, busy_o=0, stall_o=0; operand, remainder and counter registers cleared.
- States: IDLE, MUL, DIV, DONE.
- IDLE, start_i=1, flush_i=0:
  - Capture opa/opb/op; stall_o=1 this cycle.
  - Mul op: next state MUL.
  - Div op, opb≠0: next state DIV, counter=0.
  - Div op, opb=0: next state DONE with hi=opa_i, lo=32'hFFFFFFFF.
- MUL: registers the 64-bit product; next state DONE.
  - MULT: signed 32x32 product, full 64-bit two's complement.
  - MULTU: unsigned product.
- DIV: one restoring step per cycle on |a|,|b| (unsigned values for DIVU). After DIV_ITER steps (counter==31 in the last step), next state DONE.
- Signed result fixup in DONE: quotient negated if sign(a)^sign(b); remainder takes sign(a).
  - 0x80000000 / -1 gives quotient 0x80000000, remainder 0 (32-bit wrap; no trap).
- DONE: mt_hi_o=mt_lo_o=1, wdata_o={hi,lo}, where hi=product[63:32] or remainder and lo=product[31:0] or quotient. stall_o=0. Next state IDLE unconditionally. start_i seen in the following IDLE cycle is treated as a new instruction.
- stall_o = (IDLE & start_i & ~flush_i) | MUL | DIV. It is low in DONE.
- Latency, start accepted at cycle T:
  - Mul: DONE at T+2.
  - Div: DONE at T+33.
  - Divide by zero: DONE at T+1.
- flush_i in any state: next state IDLE, no DONE pulse, stall_o=0 in that same cycle.
  - flush_i and start_i together in IDLE: start is ignored.
  - flush_i in DONE: mt_hi_o/mt_lo_o are forced low.
- mt_hi_o and mt_lo_o are always equal. wdata_o holds its last value outside DONE. No consumer may use it unless the write enables are high.

Test Plan:
- MULT opa=-3 (0xFFFFFFFD), opb=5 -> stall_o high at T and T+1; at T+2 mt_hi/lo=1, wdata_o=0xFFFFFFFF_FFFFFFF1; IDLE at T+3.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> wdata_o=0xFFFFFFFE_00000001 at T+2. DIVU 100/7 -> at T+33 hi=2, lo=14; stall_o high for exactly 33 cycles.
- DIV -7/2 -> hi=0xFFFFFFFF (rem -1), lo=0xFFFFFFFD (quot -3). DIV 0x80000000/0xFFFFFFFF -> hi=0, lo=0x80000000.
- DIV 5/0 -> DONE at T+1: hi=5, lo=0xFFFFFFFF; stall_o high only in cycle T.
- DIV started, flush_i at T+10 -> stall_o low at T+10, no mt pulse ever. A new MULTU 2*3 started at T+12 -> wdata_o=6 at T+14.
- rst_i asserted asynchronously mid-divide (between edges) -> stall_o, busy_o and mt_* drop immediately. After release, back-to-back MULT then DIVU complete correctly, with start_i held continuously across the DONE->IDLE boundary.
